inputdata_sender: RTL and testbench

//  Producer side of the loaddata / inputdata_ready handshake.
//  - Assembles keypad digits (BCD) into a DIGITS-wide word.
//  - On ENTER, presents the word and raises inputdata_ready to the control unit.
//  - Holds the word stable until the control unit acknowledges by driving loaddata low.
//  - Sits between the debounced keypad decoder and the datapath control unit.

---
 rtl/inputdata_sender.sv | 107 ++++++++++
 tb/tb_inputdata_sender.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inputdata_sender.sv
// Keypad word assembler and producer side of the loaddata / inputdata_ready handshake.
// Define INPUTDATA_BCKSP_EN to treat code 0xC as BACKSPACE; otherwise 0xC is a reserved key.
module inputdata_sender #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  loaddata,
    output logic                  inputdata_ready,
    output logic [4*DIGITS-1:0]   data_out,
    output logic [3:0]            digit_count,
    output logic                  key_err
);

    // state      | meaning
    // COLLECT    | assembling digits, ready low
    // SEND       | word presented and frozen, ready high until loaddata seen low
    // RELEASE    | consumer has the word, wait for loaddata high before clearing
    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [3:0] MAX_COUNT = 4'(DIGITS);
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
`ifdef INPUTDATA_BCKSP_EN
    localparam logic [3:0] KEY_BCKSP = 4'hC;
`endif

    logic [1:0]            state;
    logic [4*DIGITS+3:0]   shifted;
    logic                  is_digit;

    // Concatenate then truncate so the shift stays legal for DIGITS == 1.
    assign shifted  = {data_out, key_code};
    assign is_digit = (key_code <= 4'd9);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_COLLECT;
            inputdata_ready <= 1'b0;
            data_out        <= '0;
            digit_count     <= 4'd0;
            key_err         <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            if (digit_count < MAX_COUNT) begin
                                data_out    <= shifted[4*DIGITS-1:0];
                                digit_count <= digit_count + 4'd1;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            data_out    <= '0;
                            digit_count <= 4'd0;
                        end else if (key_code == KEY_ENTER) begin
                            // loaddata is deliberately ignored here: ENTER always wins.
                            if (digit_count != 4'd0) begin
                                state           <= ST_SEND;
                                inputdata_ready <= 1'b1;
                            end else begin
                                key_err <= 1'b1;
                            end
`ifdef INPUTDATA_BCKSP_EN
                        end else if (key_code == KEY_BCKSP) begin
                            if (digit_count != 4'd0) begin
                                data_out    <= data_out >> 4;
                                digit_count <= digit_count - 4'd1;
                            end else begin
                                key_err <= 1'b1;
                            end
`endif
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    key_err <= key_valid;
                    if (!loaddata) begin
                        inputdata_ready <= 1'b0;
                        state           <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    key_err <= key_valid;
                    if (loaddata) begin
                        state       <= ST_COLLECT;
                        data_out    <= '0;
                        digit_count <= 4'd0;
                    end
                end
                default: begin
                    state           <= ST_COLLECT;
                    inputdata_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inputdata_sender.sv
// Bench for inputdata_sender: directed scenarios plus random key streams against a queue-based model.
module tb_inputdata_sender;

    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                key_valid = 1'b0;
    logic [3:0]          key_code = 4'd0;
    logic                loaddata = 1'b1;
    logic                inputdata_ready;
    logic [4*DIGITS-1:0] data_out;
    logic [3:0]          digit_count;
    logic                key_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: digits held oldest-first, phase 0=collect 1=send 2=release.
    int m_q[$];
    int m_phase = 0;
    bit m_err = 0;
`ifdef INPUTDATA_BCKSP_EN
    bit bcksp = 1;
`else
    bit bcksp = 0;
`endif

    inputdata_sender #(.DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .loaddata(loaddata), .inputdata_ready(inputdata_ready), .data_out(data_out),
        .digit_count(digit_count), .key_err(key_err)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] expected();
        logic [31:0] w = 0;
        foreach (m_q[i]) w = w * 16 + 32'(m_q[i]);
        return {m_phase == 1, w, 4'(m_q.size()), m_err};
    endfunction

    function automatic logic [37:0] observed();
        return {inputdata_ready, 32'(data_out), digit_count, key_err};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_err = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kc, input logic ld);
        m_err = 0;
        if (m_phase == 0) begin
            if (kv) begin
                if (kc <= 9) begin
                    if (m_q.size() < DIGITS) m_q.push_back(int'(kc));
                    else m_err = 1;
                end else if (kc == 4'hA) m_q.delete();
                else if (kc == 4'hB) begin
                    if (m_q.size() > 0) m_phase = 1;
                    else m_err = 1;
                end else if (kc == 4'hC && bcksp) begin
                    if (m_q.size() > 0) void'(m_q.pop_back());
                    else m_err = 1;
                end else m_err = 1;
            end
        end else if (m_phase == 1) begin
            m_err = kv;
            if (!ld) m_phase = 2;
        end else begin
            m_err = kv;
            if (ld) begin
                m_phase = 0;
                m_q.delete();
            end
        end
    endtask

    task automatic drive(input logic kv, input logic [3:0] kc, input logic ld);
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        loaddata  = ld;
        @(posedge clk);
        model_step(kv, kc, ld);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        n_vec++;
        if (observed() !== 38'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", observed(), 38'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] keys [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hB};
        foreach (keys[i]) begin
            drive(1'b1, keys[i], 1'b1);
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL basic_key%0d: got %h want %h", i, observed(), expected());
            end
        end
        n_vec++;
        if (data_out !== 16'h1234 || !inputdata_ready) begin
            n_err++;
            $display("FAIL basic_word: got %h ready %b want 1234 ready 1", data_out, inputdata_ready);
        end
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, 4'h0, (c < 10 || c > 12));
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL handshake_cyc%0d: got %h want %h", c, observed(), expected());
            end
        end
    endtask

    task automatic test_errors();
        logic [3:0] keys [9] = '{4'hB, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'hF, 4'hD, 4'hC};
        foreach (keys[i]) begin
            drive(1'b1, keys[i], 1'b1);
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL errors_key%0d: got %h want %h", i, observed(), expected());
            end
            drive(1'b0, 4'h0, 1'b1);
            n_vec++;
            if (key_err !== 1'b0) begin
                n_err++;
                $display("FAIL errors_pulse%0d: key_err got %b want 0", i, key_err);
            end
        end
        drive(1'b1, 4'hA, 1'b1);
    endtask

    task automatic test_clear_and_frozen();
        logic [3:0] keys [7] = '{4'h7, 4'hA, 4'h5, 4'hB, 4'h3, 4'hA, 4'hB};
        foreach (keys[i]) begin
            drive(1'b1, keys[i], 1'b1);
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL clear_key%0d: got %h want %h", i, observed(), expected());
            end
        end
        n_vec++;
        if (data_out !== 16'h0005) begin
            n_err++;
            $display("FAIL clear_word: got %h want 0005", data_out);
        end
        drive(1'b1, 4'h2, 1'b0);
        drive(1'b1, 4'h2, 1'b0);
        drive(1'b0, 4'h0, 1'b1);
        n_vec++;
        if (observed() !== expected()) begin
            n_err++;
            $display("FAIL release_keys: got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_backspace();
        logic [3:0] keys [6] = '{4'h9, 4'h8, 4'hC, 4'hB, 4'hC, 4'hC};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, keys[i], 1'b1);
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL bcksp_key%0d: got %h want %h", i, observed(), expected());
            end
        end
        drive(1'b0, 4'h0, 1'b0);
        drive(1'b0, 4'h0, 1'b1);
        for (int i = 4; i < 6; i++) begin
            drive(1'b1, keys[i], 1'b1);
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL bcksp_empty%0d: got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_reset_mid_send();
        drive(1'b1, 4'h3, 1'b1);
        drive(1'b1, 4'hB, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (observed() !== expected()) begin
            n_err++;
            $display("FAIL reset_mid_send: got %h want %h", observed(), expected());
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic       kv;
        logic [3:0] kc;
        logic       ld = 1'b1;
        for (int i = 0; i < 600; i++) begin
            kv = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       kc = 4'hB;
                1:       kc = 4'(($urandom_range(0, 3) == 0) ? 4'hA : $urandom_range(12, 15));
                default: kc = 4'($urandom_range(0, 9));
            endcase
            if ($urandom_range(0, 3) == 0) ld = ~ld;
            drive(kv, kc, ld);
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL random_step%0d: got %h want %h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_clear_and_frozen();
        test_backspace();
        test_reset_mid_send();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
